// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, and saturating
// stall/flush event counters. Stall takes priority over a taken-branch flush.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        taken_i,
    input  logic [31:0] target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_inst_i,
    output logic [31:0] pc_id_o,
    output logic [31:0] inst_id_o,
    output logic        valid_id_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic        valid_id_q, valid_id_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic do_stall, do_flush, do_fetch;

    // Stall wins over taken: branch operands are not resolved during a load-use stall.
    assign do_stall = start_i & stall_i;
    assign do_flush = start_i & ~stall_i & taken_i;
    assign do_fetch = start_i & ~stall_i & ~taken_i;

    always_comb begin
        pc_d        = pc_q;
        pc_id_d     = pc_id_q;
        inst_id_d   = inst_id_q;
        valid_id_d  = valid_id_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (do_stall) begin
            stall_cnt_d = stall_cnt_q + {31'd0, (stall_cnt_q != 32'hFFFF_FFFF)};
        end else if (do_flush) begin
            pc_d        = {target_i[31:2], 2'b00};
            pc_id_d     = pc_q;
            inst_id_d   = 32'h0;
            valid_id_d  = 1'b0;
            flush_cnt_d = flush_cnt_q + {31'd0, (flush_cnt_q != 32'hFFFF_FFFF)};
        end else if (do_fetch) begin
            pc_d       = pc_q + 32'd4;
            pc_id_d    = pc_q;
            inst_id_d  = imem_inst_i;
            valid_id_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q        <= PC_INIT;
            pc_id_q     <= 32'h0;
            inst_id_q   <= 32'h0;
            valid_id_q  <= 1'b0;
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            pc_id_q     <= pc_id_d;
            inst_id_q   <= inst_id_d;
            valid_id_q  <= valid_id_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_id_o     = pc_id_q;
    assign inst_id_o   = inst_id_q;
    assign valid_id_o  = valid_id_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: fetch, freeze, stall, flush, priority, wrap,
// async reset and counter saturation.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i, start_i, stall_i, taken_i;
    logic [31:0] target_i, imem_addr_o, imem_inst_i;
    logic [31:0] pc_id_o, inst_id_o, stall_cnt_o, flush_cnt_o;
    logic        valid_id_o;
    int          checks = 0;
    int          failures = 0;

    fetch_stage dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .stall_i(stall_i),
        .taken_i(taken_i), .target_i(target_i), .imem_addr_o(imem_addr_o),
        .imem_inst_i(imem_inst_i), .pc_id_o(pc_id_o), .inst_id_o(inst_id_o),
        .valid_id_o(valid_id_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: fixed word at 0, address-derived pattern elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00A0_0093 : {a[15:0], 16'h1337};
    endfunction
    assign imem_inst_i = imem(imem_addr_o);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"}, imem_addr_o, 32'h0);
        chk({tag, "_pcid"}, pc_id_o, 32'h0);
        chk({tag, "_inst"}, inst_id_o, 32'h0);
        chk({tag, "_vld"}, {31'd0, valid_id_o}, 32'h0);
        chk({tag, "_scnt"}, stall_cnt_o, 32'h0);
        chk({tag, "_fcnt"}, flush_cnt_o, 32'h0);
    endtask

    initial begin
        rst_n_i = 1'b0; start_i = 1'b1; stall_i = 1'b0; taken_i = 1'b0; target_i = 32'h0;
        #2;
        chk_zero("rst");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Straight-line fetch
        tick();
        chk("f1_addr", imem_addr_o, 32'h4);
        chk("f1_pcid", pc_id_o, 32'h0);
        chk("f1_inst", inst_id_o, 32'h00A0_0093);
        chk("f1_vld", {31'd0, valid_id_o}, 32'h1);
        repeat (4) tick();
        chk("f5_addr", imem_addr_o, 32'd20);
        chk("f5_pcid", pc_id_o, 32'd16);
        chk("f5_inst", inst_id_o, 32'h0010_1337);

        // Freeze: start low, hazards asserted must be ignored
        rst_n_i = 1'b0; #1; rst_n_i = 1'b1;
        start_i = 1'b0; stall_i = 1'b1; taken_i = 1'b1; target_i = 32'h40;
        repeat (3) tick();
        chk_zero("frz");
        stall_i = 1'b0; taken_i = 1'b0; start_i = 1'b1;
        tick();
        chk("res_addr", imem_addr_o, 32'h4);
        chk("res_vld", {31'd0, valid_id_o}, 32'h1);

        // Stall at PC=8
        tick();
        chk("pre_st_addr", imem_addr_o, 32'h8);
        stall_i = 1'b1;
        repeat (2) tick();
        chk("st_addr", imem_addr_o, 32'h8);
        chk("st_pcid", pc_id_o, 32'h4);
        chk("st_inst", inst_id_o, 32'h0004_1337);
        chk("st_cnt", stall_cnt_o, 32'd2);
        stall_i = 1'b0;
        tick();
        chk("ust_addr", imem_addr_o, 32'd12);
        chk("ust_pcid", pc_id_o, 32'h8);

        // Taken branch at PC=16
        tick();
        chk("pre_br_addr", imem_addr_o, 32'd16);
        taken_i = 1'b1; target_i = 32'h40;
        tick();
        chk("br_addr", imem_addr_o, 32'h40);
        chk("br_inst", inst_id_o, 32'h0);
        chk("br_vld", {31'd0, valid_id_o}, 32'h0);
        chk("br_pcid", pc_id_o, 32'd16);
        chk("br_fcnt", flush_cnt_o, 32'd1);
        taken_i = 1'b0;
        tick();
        chk("abr_pcid", pc_id_o, 32'h40);
        chk("abr_vld", {31'd0, valid_id_o}, 32'h1);
        chk("abr_inst", inst_id_o, 32'h0040_1337);

        // Misaligned target lands at 24; then stall vs taken priority
        taken_i = 1'b1; target_i = 32'h1A;
        tick();
        chk("mis_addr", imem_addr_o, 32'd24);
        stall_i = 1'b1; target_i = 32'h80;
        tick();
        chk("pri_addr", imem_addr_o, 32'd24);
        chk("pri_scnt", stall_cnt_o, 32'd3);
        chk("pri_fcnt", flush_cnt_o, 32'd2);
        stall_i = 1'b0; target_i = 32'h83;
        tick();
        chk("t83_addr", imem_addr_o, 32'h80);
        chk("t83_fcnt", flush_cnt_o, 32'd3);

        // PC wrap
        target_i = 32'hFFFF_FFFC;
        tick();
        taken_i = 1'b0;
        tick();
        chk("wrap_addr", imem_addr_o, 32'h0);
        chk("wrap_pcid", pc_id_o, 32'hFFFF_FFFC);

        // Async reset mid-cycle during a flush
        taken_i = 1'b1; target_i = 32'h100;
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk_zero("arst");
        @(negedge clk_i);
        rst_n_i = 1'b1; taken_i = 1'b0;

        // Saturation of both counters
        stall_i = 1'b1;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        repeat (2) tick();
        chk("sat_scnt", stall_cnt_o, 32'hFFFF_FFFF);
        stall_i = 1'b0; taken_i = 1'b1; target_i = 32'h20;
        force dut.flush_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.flush_cnt_q;
        tick();
        chk("sat_fcnt", flush_cnt_o, 32'hFFFF_FFFF);
        chk("sat_addr", imem_addr_o, 32'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
